// File: rtl/decode_stage.sv
// decode_stage -- instruction-decode stage of the 8-bit pipelined processor.
//
// Decodes the IF/ID instruction, reads the register file (with write-through
// bypass from write-back), detects back-to-back dependencies for the ALU
// forwarding path, and latches everything into the ID/EX pipeline register.
//
// Ports:
//   Clk              clock, rising edge
//   Reset            asynchronous active-low reset (clears ID/EX and r0-r7)
//   IF_ID_Instr      [15:14] opcode, [13:11] rd, [10:8] rs, [7:0] imm
//   IF_ID_Valid      IF_ID_Instr holds a real instruction
//   Stall            hold ID/EX contents
//   Flush            load a bubble into ID/EX (wins over Stall)
//   WB_RegWrite      write-back enable
//   WB_Write_Reg     write-back destination register
//   WB_Write_Data    write-back value
//   ID_EX_*          ID/EX pipeline register outputs toward the ALU
module decode_stage #(
    parameter int NREGS = 8,
    parameter int DW    = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [15:0]   IF_ID_Instr,
    input  logic          IF_ID_Valid,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          WB_RegWrite,
    input  logic [2:0]    WB_Write_Reg,
    input  logic [DW-1:0] WB_Write_Data,
    output logic          ID_EX_Valid,
    output logic          ID_EX_ALUSrc,
    output logic [DW-1:0] ID_EX_Read_Data,
    output logic [DW-1:0] ID_EX_Imm_Data,
    output logic [2:0]    ID_EX_Write_Reg,
    output logic          ID_EX_RegWrite,
    output logic          ID_EX_Fwd
);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LI   = 2'b01,
        OP_ADDI = 2'b10,
        OP_RSVD = 2'b11
    } opcode_t;

    opcode_t       opcode;
    logic [2:0]    rd;
    logic [2:0]    rs;
    logic [DW-1:0] imm;

    logic          dec_alu_src;
    logic          dec_reg_write;
    logic [DW-1:0] read_data;
    logic          fwd_next;

    logic [DW-1:0] regs [NREGS];

    assign opcode = opcode_t'(IF_ID_Instr[15:14]);
    assign rd     = IF_ID_Instr[13:11];
    assign rs     = IF_ID_Instr[10:8];
    assign imm    = IF_ID_Instr[7:0];

    // Reserved opcodes and invalid slots decode as nop.
    always_comb begin
        dec_alu_src   = 1'b0;
        dec_reg_write = 1'b0;
        if (IF_ID_Valid) begin
            unique case (opcode)
                OP_LI: begin
                    dec_reg_write = 1'b1;
                end
                OP_ADDI: begin
                    dec_alu_src   = 1'b1;
                    dec_reg_write = 1'b1;
                end
                default: begin
                    dec_alu_src   = 1'b0;
                    dec_reg_write = 1'b0;
                end
            endcase
        end
    end

    // Write-through: a same-cycle write-back to rs is seen by this read.
    always_comb begin
        read_data = regs[rs];
        if (WB_RegWrite && (WB_Write_Reg == rs)) begin
            read_data = WB_Write_Data;
        end
    end

    // The instruction now in ID/EX will sit in EX/WB when this one executes,
    // so its result must come off the forwarding path. Only addi reads rs,
    // hence dec_alu_src gates li/nop out.
    assign fwd_next = dec_alu_src & ID_EX_Valid & ID_EX_RegWrite
                    & (ID_EX_Write_Reg == rs);

    // Register file: write-back always commits, regardless of Stall/Flush.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_RegWrite) begin
            regs[WB_Write_Reg] <= WB_Write_Data;
        end
    end

    // ID/EX pipeline register: Flush > Stall > load.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ID_EX_Valid     <= 1'b0;
            ID_EX_ALUSrc    <= 1'b0;
            ID_EX_Read_Data <= '0;
            ID_EX_Imm_Data  <= '0;
            ID_EX_Write_Reg <= '0;
            ID_EX_RegWrite  <= 1'b0;
            ID_EX_Fwd       <= 1'b0;
        end else if (Flush) begin
            ID_EX_Valid     <= 1'b0;
            ID_EX_ALUSrc    <= 1'b0;
            ID_EX_Read_Data <= '0;
            ID_EX_Imm_Data  <= '0;
            ID_EX_Write_Reg <= '0;
            ID_EX_RegWrite  <= 1'b0;
            ID_EX_Fwd       <= 1'b0;
        end else if (!Stall) begin
            ID_EX_Valid     <= IF_ID_Valid;
            ID_EX_ALUSrc    <= dec_alu_src;
            ID_EX_Read_Data <= read_data;
            ID_EX_Imm_Data  <= imm;
            ID_EX_Write_Reg <= rd;
            ID_EX_RegWrite  <= dec_reg_write;
            ID_EX_Fwd       <= fwd_next;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- directed, scoreboard-based bench for decode_stage.
// Each step drives one cycle of stimulus on the falling edge, queues the
// ID/EX contents expected after the next rising edge, and compares them
// 1 time unit after that edge.
module tb_decode_stage;

    logic        Clk;
    logic        Reset;
    logic [15:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic        Stall;
    logic        Flush;
    logic        WB_RegWrite;
    logic [2:0]  WB_Write_Reg;
    logic [7:0]  WB_Write_Data;
    logic        ID_EX_Valid;
    logic        ID_EX_ALUSrc;
    logic [7:0]  ID_EX_Read_Data;
    logic [7:0]  ID_EX_Imm_Data;
    logic [2:0]  ID_EX_Write_Reg;
    logic        ID_EX_RegWrite;
    logic        ID_EX_Fwd;

    decode_stage #(.NREGS(8), .DW(8)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .IF_ID_Instr     (IF_ID_Instr),
        .IF_ID_Valid     (IF_ID_Valid),
        .Stall           (Stall),
        .Flush           (Flush),
        .WB_RegWrite     (WB_RegWrite),
        .WB_Write_Reg    (WB_Write_Reg),
        .WB_Write_Data   (WB_Write_Data),
        .ID_EX_Valid     (ID_EX_Valid),
        .ID_EX_ALUSrc    (ID_EX_ALUSrc),
        .ID_EX_Read_Data (ID_EX_Read_Data),
        .ID_EX_Imm_Data  (ID_EX_Imm_Data),
        .ID_EX_Write_Reg (ID_EX_Write_Reg),
        .ID_EX_RegWrite  (ID_EX_RegWrite),
        .ID_EX_Fwd       (ID_EX_Fwd)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string      tag;
        logic       valid;
        logic       alusrc;
        logic [7:0] rdata;
        logic [7:0] imm;
        logic [2:0] wr;
        logic       regw;
        logic       fwd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [15:0] enc(input logic [1:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic push(input string tag, input logic valid, input logic alusrc,
                        input logic [7:0] rdata, input logic [7:0] imm,
                        input logic [2:0] wr, input logic regw, input logic fwd);
        exp_t e;
        e.tag = tag; e.valid = valid; e.alusrc = alusrc; e.rdata = rdata;
        e.imm = imm; e.wr = wr; e.regw = regw; e.fwd = fwd;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL scoreboard_empty: got size %0d expected >0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            assert (ID_EX_Valid === e.valid) else begin
                fails++;
                $error("FAIL %s.valid: got %0h expected %0h", e.tag, ID_EX_Valid, e.valid);
            end
            tests++;
            assert (ID_EX_ALUSrc === e.alusrc) else begin
                fails++;
                $error("FAIL %s.alusrc: got %0h expected %0h", e.tag, ID_EX_ALUSrc, e.alusrc);
            end
            tests++;
            assert (ID_EX_Read_Data === e.rdata) else begin
                fails++;
                $error("FAIL %s.read_data: got %0h expected %0h", e.tag, ID_EX_Read_Data, e.rdata);
            end
            tests++;
            assert (ID_EX_Imm_Data === e.imm) else begin
                fails++;
                $error("FAIL %s.imm: got %0h expected %0h", e.tag, ID_EX_Imm_Data, e.imm);
            end
            tests++;
            assert (ID_EX_Write_Reg === e.wr) else begin
                fails++;
                $error("FAIL %s.write_reg: got %0h expected %0h", e.tag, ID_EX_Write_Reg, e.wr);
            end
            tests++;
            assert (ID_EX_RegWrite === e.regw) else begin
                fails++;
                $error("FAIL %s.regwrite: got %0h expected %0h", e.tag, ID_EX_RegWrite, e.regw);
            end
            tests++;
            assert (ID_EX_Fwd === e.fwd) else begin
                fails++;
                $error("FAIL %s.fwd: got %0h expected %0h", e.tag, ID_EX_Fwd, e.fwd);
            end
        end
    endtask

    // One pipeline cycle: drive on the falling edge, check after the rising edge.
    task automatic step(input string tag, input logic [15:0] instr, input logic ivalid,
                        input logic stall, input logic flush,
                        input logic wbe, input logic [2:0] wbr, input logic [7:0] wbd,
                        input logic valid, input logic alusrc, input logic [7:0] rdata,
                        input logic [7:0] imm, input logic [2:0] wr,
                        input logic regw, input logic fwd);
        @(negedge Clk);
        IF_ID_Instr   = instr;
        IF_ID_Valid   = ivalid;
        Stall         = stall;
        Flush         = flush;
        WB_RegWrite   = wbe;
        WB_Write_Reg  = wbr;
        WB_Write_Data = wbd;
        push(tag, valid, alusrc, rdata, imm, wr, regw, fwd);
        @(posedge Clk);
        #1;
        compare();
    endtask

    initial begin
        #20000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; IF_ID_Instr = '0; IF_ID_Valid = 1'b0; Stall = 1'b0; Flush = 1'b0;
        WB_RegWrite = 1'b0; WB_Write_Reg = '0; WB_Write_Data = '0;
        #1;
        push("reset_init", 0, 0, 8'h00, 8'h00, 3'd0, 0, 0);
        compare();
        @(negedge Clk);
        Reset = 1'b1;

        // Populate state, then drop Reset between edges.
        step("li_r2_pre", enc(2'b01, 3'd2, 3'd0, 8'h3C), 1, 0, 0, 1, 3'd5, 8'h77,
             1, 0, 8'h00, 8'h3C, 3'd2, 1, 0);
        step("addi_r5_pre", enc(2'b10, 3'd3, 3'd5, 8'h01), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 1, 8'h77, 8'h01, 3'd3, 1, 0);
        @(negedge Clk);
        IF_ID_Instr = '0; IF_ID_Valid = 1'b0;
        Reset = 1'b0;
        #1;
        push("reset_async", 0, 0, 8'h00, 8'h00, 3'd0, 0, 0);
        compare();
        #1;
        Reset = 1'b1;
        step("r5_after_reset", enc(2'b10, 3'd3, 3'd5, 8'h00), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 1, 8'h00, 8'h00, 3'd3, 1, 0);

        // li / addi decode.
        step("li_r2", enc(2'b01, 3'd2, 3'd0, 8'h3C), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 0, 8'h00, 8'h3C, 3'd2, 1, 0);
        step("addi_r3_r0", enc(2'b10, 3'd3, 3'd0, 8'h05), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 1, 8'h00, 8'h05, 3'd3, 1, 0);

        // Forwarding and its control cases.
        step("li_r1", enc(2'b01, 3'd1, 3'd0, 8'h10), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 0, 8'h00, 8'h10, 3'd1, 1, 0);
        step("addi_r4_r1_fwd", enc(2'b10, 3'd4, 3'd1, 8'h01), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 1, 8'h00, 8'h01, 3'd4, 1, 1);
        step("li_r1_a", enc(2'b01, 3'd1, 3'd1, 8'h10), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 0, 8'h00, 8'h10, 3'd1, 1, 0);
        step("li_r1_after_li_r1", enc(2'b01, 3'd1, 3'd1, 8'h20), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 0, 8'h00, 8'h20, 3'd1, 1, 0);
        step("addi_r4_r2_nofwd", enc(2'b10, 3'd4, 3'd2, 8'h01), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 1, 8'h00, 8'h01, 3'd4, 1, 0);

        // Write-through bypass, then a plain read of the written register.
        step("bypass_r6", enc(2'b10, 3'd5, 3'd6, 8'h02), 1, 0, 0, 1, 3'd6, 8'hA5,
             1, 1, 8'hA5, 8'h02, 3'd5, 1, 0);
        step("read_r6", enc(2'b10, 3'd7, 3'd6, 8'h00), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 1, 8'hA5, 8'h00, 3'd7, 1, 0);

        // Stall holds an addi whose Fwd is set; a write-back lands meanwhile.
        step("li_r2_b", enc(2'b01, 3'd2, 3'd0, 8'h11), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 0, 8'h00, 8'h11, 3'd2, 1, 0);
        step("addi_r3_r2_fwd", enc(2'b10, 3'd3, 3'd2, 8'h03), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 1, 8'h00, 8'h03, 3'd3, 1, 1);
        step("stall_1", enc(2'b01, 3'd6, 3'd1, 8'hEE), 1, 1, 0, 1, 3'd2, 8'h5A,
             1, 1, 8'h00, 8'h03, 3'd3, 1, 1);
        step("stall_2", enc(2'b10, 3'd7, 3'd3, 8'h99), 1, 1, 0, 0, 3'd0, 8'h00,
             1, 1, 8'h00, 8'h03, 3'd3, 1, 1);
        step("stall_3", enc(2'b11, 3'd1, 3'd7, 8'h42), 0, 1, 0, 0, 3'd0, 8'h00,
             1, 1, 8'h00, 8'h03, 3'd3, 1, 1);
        step("stall_flush", enc(2'b10, 3'd5, 3'd3, 8'h77), 1, 1, 1, 0, 3'd0, 8'h00,
             0, 0, 8'h00, 8'h00, 3'd0, 0, 0);
        step("read_r2_wb_in_stall", enc(2'b10, 3'd0, 3'd2, 8'h00), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 1, 8'h5A, 8'h00, 3'd0, 1, 0);

        // Reserved opcode and invalid slot decode as nop even when rs matches.
        step("reserved_op", enc(2'b11, 3'd3, 3'd0, 8'h44), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 0, 8'h00, 8'h44, 3'd3, 0, 0);
        step("li_r0", enc(2'b01, 3'd0, 3'd0, 8'h01), 1, 0, 0, 0, 3'd0, 8'h00,
             1, 0, 8'h00, 8'h01, 3'd0, 1, 0);
        step("invalid_addi", enc(2'b10, 3'd2, 3'd0, 8'h33), 0, 0, 0, 0, 3'd0, 8'h00,
             0, 0, 8'h00, 8'h33, 3'd2, 0, 0);

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
